// File: rtl/spi_arb_pkg.sv
// Shared constants for the SPI bus arbiter: FSM state encodings, counter width
// and the idle level of the MOSI pad.
package spi_arb_pkg;

  localparam int CNT_W = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_OWN   = 2'd2;
  localparam logic [1:0] ST_GUARD = 2'd3;

  localparam logic MOSI_RST = 1'b1;

endpackage

// File: rtl/spi_arb_rr_pick.sv
// Combinational winner picker for the SPI bus arbiter. Round robin from
// last_owner+1 by default; SPI_ARB_FIXED_PRIO_EN selects lowest-index-wins.
module spi_arb_rr_pick
  import spi_arb_pkg::*;
#(
  parameter int REQ_NUM = 4,
  parameter int IDX_W   = 2
) (
  input  logic [REQ_NUM-1:0] eligible,
  input  logic [IDX_W-1:0]   last_owner,
  output logic               valid,
  output logic [IDX_W-1:0]   winner
);

`ifdef SPI_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last_owner;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    // Scanning downwards leaves the lowest eligible index as the final write.
    for (int i = REQ_NUM - 1; i >= 0; i--) begin
      if (eligible[i[IDX_W-1:0]]) begin
        valid  = 1'b1;
        winner = i[IDX_W-1:0];
      end
    end
  end
`else
  always_comb begin
    int idx;
    // NOTE: every variable written here gets a default first, so no path can
    // leave it holding its old value and infer a latch.
    idx    = 0;
    valid  = 1'b0;
    winner = '0;
    // Walk the ring backwards from last_owner+REQ_NUM to last_owner+1 so the
    // nearest eligible index after the last owner is written last and wins.
    for (int k = REQ_NUM; k >= 1; k--) begin
      idx = (int'(last_owner) + k) % REQ_NUM;
      if (eligible[idx[IDX_W-1:0]]) begin
        valid  = 1'b1;
        winner = idx[IDX_W-1:0];
      end
    end
  end
`endif

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI bus between REQ_NUM masters with CS setup/guard timing and
// VS_DREQ gating. Define SPI_ARB_FIXED_PRIO_EN for fixed-priority arbitration.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int   REQ_NUM      = 4,
  parameter int   SETUP_CYCLES = 2,
  parameter int   GUARD_CYCLES = 4,
  parameter int   DREQ_IDX     = 2,
  parameter logic SCK_IDLE     = 1'b0,
  localparam int  IDX_W        = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REQ_NUM-1:0] req_i,
  output logic [REQ_NUM-1:0] gnt_o,
  input  logic [REQ_NUM-1:0] sck_i,
  input  logic [REQ_NUM-1:0] mosi_i,
  output logic [REQ_NUM-1:0] miso_o,
  output logic               sck_o,
  output logic               mosi_o,
  input  logic               miso_i,
  output logic [REQ_NUM-1:0] cs_n_o,
  input  logic               dreq_i,
  output logic [IDX_W-1:0]   owner_o,
  output logic               busy_o
);

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   last_owner;
  logic [REQ_NUM-1:0] eligible;
  logic [REQ_NUM-1:0] owner_onehot;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_winner;

  // The audio master only competes while the decoder signals it can take data.
  always_comb begin
    eligible = req_i;
    if (!dreq_i) eligible[DREQ_IDX] = 1'b0;
  end

  spi_arb_rr_pick #(
    .REQ_NUM (REQ_NUM),
    .IDX_W   (IDX_W)
  ) u_pick (
    .eligible   (eligible),
    .last_owner (last_owner),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  localparam logic [1:0] ST_RELEASE = (GUARD_CYCLES == 0) ? ST_IDLE : ST_GUARD;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      owner      <= '0;
      last_owner <= IDX_W'(REQ_NUM - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            state      <= ST_SETUP;
            owner      <= pick_winner;
            last_owner <= pick_winner;
            cnt        <= '0;
          end
        end
        ST_SETUP: begin
          if (!req_i[owner]) begin
            state <= ST_RELEASE;
            cnt   <= '0;
          end else if (cnt == CNT_W'(SETUP_CYCLES - 1)) begin
            state <= ST_OWN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_OWN: begin
          if (!req_i[owner]) begin
            state <= ST_RELEASE;
            cnt   <= '0;
          end
        end
        ST_GUARD: begin
          if (cnt == CNT_W'(GUARD_CYCLES - 1)) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Pad-side muxing follows the registered owner with no added latency.
  assign owner_onehot = REQ_NUM'(1) << owner;
  assign gnt_o   = (state == ST_OWN) ? owner_onehot : '0;
  assign cs_n_o  = (state == ST_SETUP || state == ST_OWN) ? ~owner_onehot : '1;
  assign sck_o   = (state == ST_OWN) ? sck_i[owner]  : SCK_IDLE;
  assign mosi_o  = (state == ST_OWN) ? mosi_i[owner] : MOSI_RST;
  assign miso_o  = {REQ_NUM{miso_i}} & gnt_o;
  assign owner_o = owner;
  assign busy_o  = (state != ST_IDLE);

endmodule
